// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder/subtractor. One full adder plus a carry
//            flip-flop processes one operand bit per clock, LSB first.
//            Subtraction is a + ~b + 1 (operand B inverted, carry seeded 1).
// Ports    : clk_i     - rising-edge clock
//            rst_ni    - asynchronous active-low reset
//            start_i   - begin an operation (ignored while busy)
//            sub_i     - 0 = add, 1 = subtract (sampled with start)
//            op_a_i    - operand A (sampled with start)
//            op_b_i    - operand B (sampled with start)
//            busy_o    - operation in progress (RUN or DONE)
//            done_o    - one-cycle pulse, result/cout/ovf valid
//            result_o  - sum / difference
//            cout_o    - carry out of the MSB (subtract: 1 = no borrow)
//            ovf_o     - two's-complement signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic               carry_q,  carry_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;

    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_sum;
    logic               w_carry;

    // Single-bit full adder on the current bit position
    assign w_a_bit = a_q[cnt_q];
    assign w_b_bit = b_q[cnt_q];
    assign w_sum   = w_a_bit ^ w_b_bit ^ carry_q;
    assign w_carry = (w_a_bit & w_b_bit) | (w_a_bit & carry_q) | (w_b_bit & carry_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d      = op_a_i;
                    // Subtract as a + ~b + 1: invert B and seed the carry
                    b_d      = sub_i ? ~op_b_i : op_b_i;
                    carry_d  = sub_i;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[cnt_q] = w_sum;
                carry_d         = w_carry;
                if (cnt_q == LAST_IDX) begin
                    cout_d  = w_carry;
                    // carry_q is the carry into the MSB at this point
                    ovf_d   = carry_q ^ w_carry;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;

endmodule
`default_nettype wire
